// File: rtl/hazard_ctrl.sv
// Hazard/forwarding sequencer for the 5-stage pipe: stall/flush/freeze, EXE operand select and
// data-memory handshake with timeout. Optional performance counters under `HAZARD_PERF_EN`.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic       branch_id,
  input  logic       taken_id,
  input  logic [4:0] rs_exe,
  input  logic [4:0] rt_exe,
  input  logic       regwrite_exe,
  input  logic       memtoreg_exe,
  input  logic [4:0] regaddr_exe,
  input  logic       regwrite_mem,
  input  logic       memtoreg_mem,
  input  logic       memwrite_mem,
  input  logic [4:0] regaddr_mem,
  input  logic       regwrite_wb,
  input  logic [4:0] regaddr_wb,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_exe,
  output logic       freeze,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN = 2'b00, S_WAIT = 2'b01, S_ERR = 2'b10} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state_r;
  logic [7:0] wait_cnt_r;
  logic       mem_err_r;
  logic       acc_s;
  logic       lu_s;
  logic       br_hz_s;
  logic       freeze_s;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wr_mem,
                                         input logic [4:0] a_mem, input logic wr_wb,
                                         input logic [4:0] a_wb);
    logic [1:0] sel;
    if (wr_mem && (a_mem != 5'd0) && (a_mem == src)) begin
      sel = 2'b10;
    end else if (wr_wb && (a_wb != 5'd0) && (a_wb == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic match_x(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rt);
    return (r != 5'd0) && ((r == rs) || (use_rt && (r == rt)));
  endfunction

  // Hazard detection, forwarding and the prioritised stall/flush/freeze outputs
  always_comb begin
    acc_s   = memtoreg_mem | memwrite_mem;
    lu_s    = memtoreg_exe && regwrite_exe && match_x(regaddr_exe, rs_id, rt_id, uses_rt_id);
    br_hz_s = branch_id &&
              ((regwrite_exe && match_x(regaddr_exe, rs_id, rt_id, uses_rt_id)) ||
               (memtoreg_mem && match_x(regaddr_mem, rs_id, rt_id, uses_rt_id)));
    fwd_a   = fwd_sel(rs_exe, regwrite_mem, regaddr_mem, regwrite_wb, regaddr_wb);
    fwd_b   = fwd_sel(rt_exe, regwrite_mem, regaddr_mem, regwrite_wb, regaddr_wb);

    // The pipe is released in the very cycle the memory answers
    freeze_s = 1'b0;
    case (state_r)
      S_RUN:   freeze_s = acc_s && !dmem_ready;
      S_WAIT:  freeze_s = !dmem_ready;
      S_ERR:   freeze_s = 1'b1;
      default: freeze_s = 1'b0;
    endcase

    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    freeze    = 1'b0;
    if (rst) begin
      freeze = 1'b0;
    end else if (freeze_s) begin
      freeze = 1'b1;
    end else if (lu_s || br_hz_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_exe = 1'b1;
    end else if (branch_id && taken_id) begin
      flush_id = 1'b1;
    end else begin
      flush_id = 1'b0;
    end

    dmem_req = !rst && acc_s && (state_r != S_ERR);
    mem_err  = mem_err_r;
  end

  // Memory handshake FSM with wait-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_RUN;
      wait_cnt_r <= 8'd0;
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        S_RUN: begin
          if (acc_s && !dmem_ready) begin
            state_r    <= S_WAIT;
            wait_cnt_r <= 8'd1;
          end else begin
            wait_cnt_r <= 8'd0;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state_r    <= S_RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_r   <= S_ERR;
            mem_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_ERR: begin
          mem_err_r <= 1'b1;
        end
        default: begin
          state_r    <= S_RUN;
          wait_cnt_r <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] freeze_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= '0;
      freeze_cnt_r <= '0;
      flush_cnt_r  <= '0;
    end else begin
      if (stall_id && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      if (freeze && (freeze_cnt_r != CNT_MAX)) freeze_cnt_r <= freeze_cnt_r + CNT_ONE;
      if ((flush_id || flush_exe) && (flush_cnt_r != CNT_MAX)) flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign freeze_cnt = freeze_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic, every cycle
// predicted by a rule-level reference model and checked by an independent monitor.
module tb_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_id, rt_id, rs_exe, rt_exe, regaddr_exe, regaddr_mem, regaddr_wb;
  logic uses_rt_id, branch_id, taken_id, regwrite_exe, memtoreg_exe;
  logic regwrite_mem, memtoreg_mem, memwrite_mem, regwrite_wb, dmem_ready;
  logic dmem_req, stall_if, stall_id, flush_id, flush_exe, freeze, mem_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .branch_id(branch_id), .taken_id(taken_id), .rs_exe(rs_exe), .rt_exe(rt_exe),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .regaddr_exe(regaddr_exe),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .regaddr_mem(regaddr_mem), .regwrite_wb(regwrite_wb), .regaddr_wb(regaddr_wb),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_exe(flush_exe), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall_if, stall_id, flush_id, flush_exe, freeze, dmem_req, mem_err;
    logic [1:0] fwd_a, fwd_b;
    int         c_stall, c_freeze, c_flush;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;

  // reference model state: sticky error, access outstanding, unanswered cycles so far
  bit m_err, m_busy;
  int m_n, m_cs, m_cf, m_cl;

  function automatic bit mx(logic [4:0] r);
    return (r != 5'd0) && (r == rs_id || (uses_rt_id && r == rt_id));
  endfunction

  function automatic logic [1:0] fsel(logic [4:0] src);
    if (regwrite_mem && regaddr_mem != 5'd0 && regaddr_mem == src) return 2'b10;
    if (regwrite_wb && regaddr_wb != 5'd0 && regaddr_wb == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit acc, fz, hz, live;
    acc  = memtoreg_mem || memwrite_mem;
    fz   = m_err || ((m_busy || acc) && !dmem_ready);
    hz   = (memtoreg_exe && regwrite_exe && mx(regaddr_exe)) ||
           (branch_id && ((regwrite_exe && mx(regaddr_exe)) || (memtoreg_mem && mx(regaddr_mem))));
    live = !rst;
    e.freeze    = live && fz;
    e.stall_if  = live && !fz && hz;
    e.stall_id  = e.stall_if;
    e.flush_exe = e.stall_if;
    e.flush_id  = live && !fz && !hz && branch_id && taken_id;
    e.dmem_req  = live && acc && !m_err;
    e.mem_err   = m_err;
    e.fwd_a     = fsel(rs_exe);
    e.fwd_b     = fsel(rt_exe);
    e.c_stall   = m_cs;
    e.c_freeze  = m_cf;
    e.c_flush   = m_cl;
    return e;
  endfunction

  function automatic int sat(int v, bit inc);
    int mx_v = (1 << CNT_W) - 1;
    return (inc && v < mx_v) ? v + 1 : v;
  endfunction

  // advance the model across a clock edge using the inputs of the cycle that just ended
  task automatic model_edge();
    if (rst) begin
      m_err = 0; m_busy = 0; m_n = 0; m_cs = 0; m_cf = 0; m_cl = 0;
    end else begin
      m_cs = sat(m_cs, last_e.stall_id);
      m_cf = sat(m_cf, last_e.freeze);
      m_cl = sat(m_cl, last_e.flush_id || last_e.flush_exe);
      if (!m_err && (m_busy || memtoreg_mem || memwrite_mem)) begin
        if (dmem_ready) begin
          m_busy = 0; m_n = 0;
        end else begin
          m_busy = 1; m_n++;
          if (m_n > TO) m_err = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic push();
    last_e = predict();
    q.push_back(last_e);
  endtask

  task automatic idle();
    rst = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0; branch_id = 0; taken_id = 0;
    rs_exe = 0; rt_exe = 0; regwrite_exe = 0; memtoreg_exe = 0; regaddr_exe = 0;
    regwrite_mem = 0; memtoreg_mem = 0; memwrite_mem = 0; regaddr_mem = 0;
    regwrite_wb = 0; regaddr_wb = 0; dmem_ready = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expectation per cycle and compares on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_if", int'(stall_if), int'(e.stall_if));
        chk("stall_id", int'(stall_id), int'(e.stall_id));
        chk("flush_id", int'(flush_id), int'(e.flush_id));
        chk("flush_exe", int'(flush_exe), int'(e.flush_exe));
        chk("freeze", int'(freeze), int'(e.freeze));
        chk("dmem_req", int'(dmem_req), int'(e.dmem_req));
        chk("mem_err", int'(mem_err), int'(e.mem_err));
        chk("fwd_a", int'(fwd_a), int'(e.fwd_a));
        chk("fwd_b", int'(fwd_b), int'(e.fwd_b));
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", int'(stall_cnt), e.c_stall);
        chk("freeze_cnt", int'(freeze_cnt), e.c_freeze);
        chk("flush_cnt", int'(flush_cnt), e.c_flush);
`endif
      end
    end
  end

  // stimulus: directed scenarios, then randomized traffic
  initial begin
    bit slow;
    m_err = 0; m_busy = 0; m_n = 0; m_cs = 0; m_cf = 0; m_cl = 0;
    idle();
    rst = 1;
    last_e = predict();
    repeat (2) begin tick(); rst = 1; push(); end

    // forwarding priority, then WB path when MEM writes r0
    tick(); idle(); regwrite_mem = 1; regaddr_mem = 5'd8; rs_exe = 5'd8; rt_exe = 5'd8;
    regwrite_wb = 1; regaddr_wb = 5'd8; push();
    tick(); regaddr_mem = 5'd0; push();
    // load-use through rt, with and without rt being read
    tick(); idle(); memtoreg_exe = 1; regwrite_exe = 1; regaddr_exe = 5'd9; rt_id = 5'd9;
    uses_rt_id = 1; push();
    tick(); uses_rt_id = 0; push();
    // taken branch alone, then with an EXE write to rs
    tick(); idle(); branch_id = 1; taken_id = 1; rs_id = 5'd3; push();
    tick(); regwrite_exe = 1; regaddr_exe = 5'd3; push();
    // slow load: three not-ready cycles then ready
    tick(); idle(); memtoreg_mem = 1; push();
    repeat (2) begin tick(); push(); end
    tick(); dmem_ready = 1; push();
    tick(); idle(); push();
    // store that never completes: timeout, then reset clears
    tick(); idle(); memwrite_mem = 1; push();
    repeat (7) begin tick(); push(); end
    tick(); rst = 1; push();
    tick(); rst = 0; memwrite_mem = 0; push();
    tick(); push();

    slow = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc % 150 == 0) slow = ~slow;
      rst          = ($urandom_range(0, 69) == 0);
      rs_id        = 5'($urandom_range(0, 3));
      rt_id        = 5'($urandom_range(0, 3));
      rs_exe       = 5'($urandom_range(0, 3));
      rt_exe       = 5'($urandom_range(0, 3));
      regaddr_exe  = 5'($urandom_range(0, 3));
      regaddr_wb   = 5'($urandom_range(0, 3));
      uses_rt_id   = 1'($urandom);
      branch_id    = 1'($urandom);
      taken_id     = 1'($urandom);
      regwrite_exe = 1'($urandom);
      memtoreg_exe = 1'($urandom);
      regwrite_mem = 1'($urandom);
      regwrite_wb  = 1'($urandom);
      if (!last_e.freeze) begin
        regaddr_mem  = 5'($urandom_range(0, 3));
        memtoreg_mem = ($urandom_range(0, 3) == 0);
        memwrite_mem = ($urandom_range(0, 4) == 0);
      end
      dmem_ready   = slow ? ($urandom_range(0, 9) == 0) : 1'($urandom);
      push();
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
